// File: rtl/exc_ctrl_if.sv
// Decoder <-> exception-control bundle: exception request/return in, redirect and saved state out.
interface exc_ctrl_if #(
  parameter int unsigned PC_W = 64
);
  localparam int unsigned ES_W = 4;

  logic            Exc;
  logic [ES_W-1:0] EStatus;
  logic [PC_W-1:0] PC_E;
  logic            ERet;
  logic            Flush;
  logic            PCRedir;
  logic [PC_W-1:0] PCRedirAddr;
  logic            ExtIAck;
  logic [PC_W-1:0] ELR;
  logic [ES_W-1:0] ESR;
  logic            InHandler;

  // Decoder / pipeline side
  modport master (
    output Exc, EStatus, PC_E, ERet,
    input  Flush, PCRedir, PCRedirAddr, ExtIAck, ELR, ESR, InHandler
  );

  // Exception controller side
  modport slave (
    input  Exc, EStatus, PC_E, ERet,
    output Flush, PCRedir, PCRedirAddr, ExtIAck, ELR, ESR, InHandler
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception control: captures return PC/cause, sequences flush and vector redirect,
// masks exceptions while the handler runs, and redirects back on exception return.
module exc_ctrl #(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] VEC_ADDR = PC_W'(64'h0000_0000_0000_00D8)
) (
  input  logic     clk,
  input  logic     reset,
  exc_ctrl_if.slave bus
);

  localparam int unsigned ES_W    = 4;
  localparam logic [ES_W-1:0] ES_IRQ = ES_W'(4'b0001);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    VEC     = 3'd2,
    HANDLER = 3'd3,
    RET     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            capture;
  logic [PC_W-1:0] elr_q;
  logic [ES_W-1:0] esr_q;

  logic            flush_q, flush_d;
  logic            redir_q, redir_d;
  logic [PC_W-1:0] redir_addr_q, redir_addr_d;
  logic            ack_q, ack_d;
  logic            in_handler_q, in_handler_d;

  // Next state, capture strobe, and outputs decoded from the state being entered
  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    flush_d      = 1'b0;
    redir_d      = 1'b0;
    redir_addr_d = '0;
    ack_d        = 1'b0;
    in_handler_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Exc) begin
          capture = 1'b1;
          state_d = FLUSH;
        end
      end
      FLUSH:   state_d = VEC;
      VEC:     state_d = HANDLER;
      HANDLER: if (bus.ERet) state_d = RET;
      RET:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // ESR is already captured by the time VEC is entered, so the ack can use it
    case (state_d)
      FLUSH: flush_d = 1'b1;
      VEC: begin
        redir_d      = 1'b1;
        redir_addr_d = VEC_ADDR;
        ack_d        = (esr_q == ES_IRQ);
      end
      HANDLER: in_handler_d = 1'b1;
      RET: begin
        redir_d      = 1'b1;
        redir_addr_d = elr_q;
      end
      default: ;
    endcase
  end

  // State, saved link/status, and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      elr_q        <= '0;
      esr_q        <= '0;
      flush_q      <= 1'b0;
      redir_q      <= 1'b0;
      redir_addr_q <= '0;
      ack_q        <= 1'b0;
      in_handler_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush_d;
      redir_q      <= redir_d;
      redir_addr_q <= redir_addr_d;
      ack_q        <= ack_d;
      in_handler_q <= in_handler_d;
      if (capture) begin
        elr_q <= bus.PC_E;
        esr_q <= bus.EStatus;
      end
    end
  end

  assign bus.Flush       = flush_q;
  assign bus.PCRedir     = redir_q;
  assign bus.PCRedirAddr = redir_addr_q;
  assign bus.ExtIAck     = ack_q;
  assign bus.InHandler   = in_handler_q;
  assign bus.ELR         = elr_q;
  assign bus.ESR         = esr_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: a schedule-based reference model pushes the expected
// output frame for every cycle; a monitor pops and compares on the falling edge.
module tb_exc_ctrl;

  localparam int unsigned PC_W = 64;
  localparam logic [63:0] VEC  = 64'hD8;

  typedef struct packed {
    logic        flush;
    logic        redir;
    logic [63:0] addr;
    logic        ack;
    logic        inh;
    logic [63:0] elr;
    logic [3:0]  esr;
  } exp_t;

  logic clk;
  logic reset;
  exc_ctrl_if #(.PC_W(PC_W)) bus ();

  exc_ctrl #(.PC_W(PC_W), .VEC_ADDR(64'hD8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  exp_t        sched[$];
  bit          handler;
  logic [63:0] m_elr;
  logic [3:0]  m_esr;
  int          tests;
  int          fails;
  int          cyc;

  // Reference: once an exception is taken the next frames are fixed; only IDLE
  // and HANDLER look at inputs.
  task automatic model_step();
    exp_t e, f;
    e = '0;
    if (!reset) begin
      sched.delete();
      handler = 0;
      m_elr   = '0;
      m_esr   = '0;
    end else if (sched.size() > 0) begin
      e = sched.pop_front();
    end else if (handler) begin
      if (bus.ERet) begin
        e.redir = 1'b1;
        e.addr  = m_elr;
        handler = 0;
        f = '0;
        sched.push_back(f);
      end else begin
        e.inh = 1'b1;
      end
    end else if (bus.Exc) begin
      m_elr   = bus.PC_E;
      m_esr   = bus.EStatus;
      e.flush = 1'b1;
      f = '0;
      f.redir = 1'b1;
      f.addr  = VEC;
      f.ack   = (bus.EStatus == 4'b0001);
      sched.push_back(f);
      f = '0;
      f.inh = 1'b1;
      sched.push_back(f);
      handler = 1;
    end
    e.elr = m_elr;
    e.esr = m_esr;
    sb.push_back(e);
  endtask

  // Apply inputs for one edge, let the model see the same sampled values
  task automatic step(input logic r, input logic ex, input logic [3:0] es,
                      input logic [63:0] pc, input logic er);
    reset       = r;
    bus.Exc     = ex;
    bus.EStatus = es;
    bus.PC_E    = pc;
    bus.ERet    = er;
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0, 64'h0, 1'b0);
  endtask

  // Monitor: compare every presented cycle against the oldest expectation
  initial begin
    exp_t e, g;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        g.flush = bus.Flush;
        g.redir = bus.PCRedir;
        g.addr  = bus.PCRedirAddr;
        g.ack   = bus.ExtIAck;
        g.inh   = bus.InHandler;
        g.elr   = bus.ELR;
        g.esr   = bus.ESR;
        tests++;
        if (g !== e) begin
          fails++;
          $display("FAIL frame cyc%0d: got flush=%b redir=%b addr=%h ack=%b inh=%b elr=%h esr=%h, want flush=%b redir=%b addr=%h ack=%b inh=%b elr=%h esr=%h",
                   cyc, g.flush, g.redir, g.addr, g.ack, g.inh, g.elr, g.esr,
                   e.flush, e.redir, e.addr, e.ack, e.inh, e.elr, e.esr);
        end
      end
    end
  end

  initial begin
    logic [3:0] es;
    tests = 0; fails = 0; cyc = 0; handler = 0;
    m_elr = '0; m_esr = '0;
    reset = 1'b0; bus.Exc = 1'b0; bus.EStatus = '0; bus.PC_E = '0; bus.ERet = 1'b0;
    #2;
    // Reset
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, 64'h0, 1'b0);
    idle(2);
    // Undefined-instruction trap and return
    step(1'b1, 1'b1, 4'b0010, 64'h40, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 4'h0, 64'h0, 1'b1);
    idle(2);
    // IRQ acknowledge, masking inside the handler, then return
    step(1'b1, 1'b1, 4'b0001, 64'h100, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 4'b0010, 64'h200, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 4'h0, 64'h0, 1'b1);
    idle(2);
    // ERet and Exc together in HANDLER
    step(1'b1, 1'b1, 4'b0001, 64'h300, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 4'b0010, 64'h380, 1'b1);
    idle(2);
    // Reset during FLUSH, then during HANDLER, then normal acceptance
    step(1'b1, 1'b1, 4'b0010, 64'h400, 1'b0);
    step(1'b0, 1'b0, 4'h0, 64'h0, 1'b0);
    idle(1);
    step(1'b1, 1'b1, 4'b0010, 64'h500, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 4'h0, 64'h0, 1'b0);
    idle(1);
    step(1'b1, 1'b1, 4'b1010, 64'h600, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 4'h0, 64'h0, 1'b1);
    idle(2);
    // Stray ERet in IDLE
    step(1'b1, 1'b0, 4'h0, 64'h0, 1'b1);
    idle(1);
    // Level IRQ held through RET recaptures on the first IDLE edge
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'b0001, 64'h700, 1'b0);
    step(1'b1, 1'b1, 4'b0001, 64'h704, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b0001, 64'h708 + 64'(i), 1'b0);
    idle(3);
    step(1'b1, 1'b0, 4'h0, 64'h0, 1'b1);
    idle(2);
    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) es = 4'($urandom_range(0, 15));
      else es = ($urandom_range(0, 1) == 0) ? 4'b0001 : 4'b0010;
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) == 0), es,
           {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
    end
    idle(3);
    @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception control stage sitting directly downstream of the main decoder. It consumes the decoder's `Exc`/`EStatus` pair and the PC of the offending instruction, and saves the return address and cause. It then sequences a pipeline flush and a PC redirect to the exception vector. While the handler runs, new exceptions are masked. On `ERet` it redirects the PC back to the saved return address.

## Interface
Parameters:
- `PC_W`, 64, PC and address width
- `VEC_ADDR`, 64'h0000_0000_0000_00D8, exception vector address

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-low
- `Exc`  in  1  exception request from the main decoder
- `EStatus`  in  4  cause code: 0001 = external IRQ, 0010 = undefined instruction
- `PC_E`  in  PC_W  PC of the instruction currently presented to the decoder
- `ERet`  in  1  decoded exception-return instruction, valid for one cycle
- `Flush`  out  1  kill in-flight instructions in the pipeline
- `PCRedir`  out  1  force the next fetch to `PCRedirAddr`
- `PCRedirAddr`  out  PC_W  redirect target
- `ExtIAck`  out  1  one-cycle acknowledge to the external interrupt source
- `ELR`  out  PC_W  saved exception link register
- `ESR`  out  4  saved exception status register
- `InHandler`  out  1  high while exceptions are masked

## Operation
- Five-state Moore FSM: IDLE, FLUSH, VEC, HANDLER, RET.
  - All control outputs decode from state only.
  - `ELR`/`ESR` are registers.
- **IDLE:**
  - `Exc`=1 → capture `ELR`<=`PC_E` and `ESR`<=`EStatus`, then go to FLUSH.
  - `EStatus` is captured verbatim, including unlisted codes.
  - `ERet` in IDLE is ignored.
- **FLUSH:** `Flush`=1 for one cycle; go to VEC unconditionally.
- **VEC:**
  - `PCRedir`=1, `PCRedirAddr`=`VEC_ADDR`.
  - `ExtIAck`=1 if `ESR`==4'b0001.
  - Go to HANDLER.
- **HANDLER:**
  - `InHandler`=1.
  - `Exc` is ignored; `ELR`/`ESR` are not overwritten.
  - `ERet`=1 → go to RET.
  - `ERet` and `Exc` in the same cycle → `ERet` wins.
- **RET:** `PCRedir`=1, `PCRedirAddr`=`ELR`; go to IDLE. `ELR`/`ESR` retain their values.
- **Interrupt is level-sensitive:** an IRQ still asserted after RET re-enters via `Exc` in IDLE on the next sample. No internal pending latch exists.
- **Output defaults in every state not listed:**
  - `Flush`, `PCRedir`, `ExtIAck`, `InHandler` = 0.
  - `PCRedirAddr` = 0.

## Timing
- **Reset:** `reset`=0 at a rising edge → next cycle has the following values, regardless of current state (including mid-sequence):
  - state = IDLE
  - `ELR` = 0, `ESR` = 0
  - every output = 0
- Reset takes priority over all inputs.
- **Exception latency:** `Exc` sampled high at edge N (state IDLE) →
  - cycle N+1: FLUSH, `Flush`=1, `ELR`/`ESR` valid.
  - cycle N+2: VEC, `PCRedir`=1.
  - cycle N+3: HANDLER, `InHandler`=1.
- **Return latency:** `ERet` sampled high at edge M (state HANDLER) →
  - cycle M+1: RET, `PCRedir`=1 to `ELR`.
  - cycle M+2: IDLE.
- **Back-to-back:** `Exc` high in the RET cycle is ignored. The earliest new capture is the first IDLE cycle (M+2).
- `ExtIAck`, `Flush` and `PCRedir` are each exactly one cycle wide per event.
- All inputs are sampled only at rising `clk`.

## Test plan
- **Undefined-instruction trap:**
  - Stimulus: `Exc`=1, `EStatus`=0010, `PC_E`=0x40 at edge 0.
  - Cycle 1: `Flush`=1, `ELR`=0x40, `ESR`=0010.
  - Cycle 2: `PCRedir`=1, `PCRedirAddr`=0xD8, `ExtIAck`=0.
  - Cycle 3: `InHandler`=1.
- **IRQ acknowledge:** `Exc`=1, `EStatus`=0001, `PC_E`=0x100 → `ExtIAck`=1 only in the VEC cycle; `ESR`=0001.
- **Masking and return:**
  - In HANDLER, pulse `Exc` with `EStatus`=0010, `PC_E`=0x200 → `ELR` stays 0x100.
  - Then `ERet`=1 → next cycle `PCRedir`=1 to 0x100; following cycle IDLE.
- **Simultaneous events:** `ERet`=1 and `Exc`=1 together in HANDLER → RET taken; `ELR`/`ESR` unchanged.
- **Reset mid-operation:** assert `reset`=0 during FLUSH, then during HANDLER → next cycle all outputs 0, `ELR`=0, `ESR`=0. A subsequent `Exc` is accepted normally.
- **Stray ERet and level IRQ:**
  - `ERet` pulsed in IDLE → no output change.
  - `Exc` held high through RET → recapture occurs at the first IDLE edge, not during RET.
